nn_input_loader: RTL

//  Upstream feeder for NeuralNetwork. Accepts a byte-serial pixel stream (valid/ready),

---
 rtl/nn_input_loader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nn_input_loader.sv
// Byte-serial pixel loader for NeuralNetwork: assembles one frame into NNin and holds it until inference completes.
// Optional build macro NN_INPUT_CLAMP_EN clamps accepted bytes with the MSB set to 0x7F.
module nn_input_loader #(
    parameter int dataWidth = 8,
    parameter int numInputs = 784,
    parameter int cntWidth  = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [dataWidth-1:0]             in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [numInputs*dataWidth-1:0]   NNin,
    output logic                             NNvalid,
    input  logic                             NNoutValid,
    output logic                             busy,
    output logic                             frame_err,
    output logic [15:0]                      frame_count
);

    localparam int FrameBits = numInputs * dataWidth;
    localparam int BaseW     = $clog2(FrameBits);
    localparam logic [cntWidth-1:0] LastIdx = cntWidth'(numInputs - 1);

    typedef enum logic [0:0] {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [cntWidth-1:0]    idx_q, idx_d;
    logic [FrameBits-1:0]   nnin_q, nnin_d;
    logic                   nnvalid_q, nnvalid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   accept_s;
    logic [BaseW-1:0]       base_s;

    function automatic logic [dataWidth-1:0] store_byte(input logic [dataWidth-1:0] b);
`ifdef NN_INPUT_CLAMP_EN
        if (b[dataWidth-1]) begin
            store_byte = {1'b0, {(dataWidth-1){1'b1}}};
        end else begin
            store_byte = b;
        end
`else
        store_byte = b;
`endif
    endfunction

    // Next-state, frame assembly and registered-output decode
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        nnin_d        = nnin_q;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;
        accept_s      = in_valid && in_ready_q;
        // First pixel lands in the MSBs of the flat frame
        base_s        = BaseW'(FrameBits - 1) - (BaseW'(idx_q) * BaseW'(dataWidth));

        case (state_q)
            S_LOAD: begin
                if (accept_s) begin
                    nnin_d[base_s -: dataWidth] = store_byte(in_data);
                    if (idx_q == LastIdx) begin
                        state_d     = S_RUN;
                        idx_d       = '0;
                        frame_err_d = !in_last;
                    end else if (in_last) begin
                        idx_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d       = idx_q + cntWidth'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            S_RUN: begin
                if (NNoutValid) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_LOAD;
                idx_d   = '0;
            end
        endcase

        // NNvalid trails the state by one cycle; in_ready drops with RUN entry but returns only after NNvalid falls
        nnvalid_d  = (state_q == S_RUN);
        in_ready_d = (state_q == S_LOAD) && (state_d == S_LOAD);
        busy_d     = (state_d == S_RUN);

        if (nnvalid_d && !nnvalid_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            idx_q         <= '0;
            nnin_q        <= '0;
            nnvalid_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            nnin_q        <= nnin_d;
            nnvalid_q     <= nnvalid_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign NNin        = nnin_q;
    assign NNvalid     = nnvalid_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule
